// File: rtl/mux_sel_pack.sv
// Shared types and helpers for the mux select-code stepper.
// Provides the sequencer state enum and the counter width function.
package mux_sel_pack;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MOVE   = 2'd1,
        SETTLE = 2'd2
    } state_e;

    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/mux_sel_stepper_timer.sv
// Loadable down-counter with a terminal-count flag (cnt == 0).
// Ports: clk, rstb, load/load_val (priority), en (decrement), cnt, tc.
module cycle_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rstb,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] cnt,
    output logic         tc
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
    assign tc  = (cnt_q == '0);

endmodule

// File: rtl/mux_sel_stepper.sv
// Walks a mux select code one LSB per STEP_CYC toward a requested target.
// Ports: req_valid/req_code/req_ready in, sel/blank/busy/done out.
module mux_sel_stepper
    import mux_sel_pack::*;
#(
    parameter int N_BITS     = 4,
    parameter int STEP_CYC   = 4,
    parameter int SETTLE_CYC = 8,
    parameter int RST_CODE   = 0
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              req_valid,
    input  logic [N_BITS-1:0] req_code,
    output logic              req_ready,
    output logic [N_BITS-1:0] sel,
    output logic              blank,
    output logic              busy,
    output logic              done
);

    localparam int CW = cnt_width(STEP_CYC, SETTLE_CYC);
    localparam logic [CW-1:0] STEP_LD   = CW'(STEP_CYC - 1);
    localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE_CYC - 1);
    localparam logic [N_BITS-1:0] RST_SEL = N_BITS'(RST_CODE);

    if (N_BITS < 1 || STEP_CYC < 2 || SETTLE_CYC < 1 ||
        RST_CODE < 0 || RST_CODE >= (1 << N_BITS)) begin : g_bad_param
        $error("mux_sel_stepper: illegal parameter set");
    end

    state_e            state_q, state_d;
    logic [N_BITS-1:0] sel_q, sel_d;
    logic [N_BITS-1:0] target_q, target_d;
    logic              up_q, up_d;
    logic              blank_q, blank_d;
    logic              stepped_q, stepped_d;
    logic              zero_q, zero_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;

    logic              tm_load;
    logic              tm_en;
    logic [CW-1:0]     tm_val;
    logic [CW-1:0]     tm_cnt;
    logic              tm_tc;

    // Step and settle phases never overlap, so one timer serves both.
    cycle_timer #(.W(CW)) u_timer (
        .clk      (clk),
        .rstb     (rstb),
        .load     (tm_load),
        .en       (tm_en),
        .load_val (tm_val),
        .cnt      (tm_cnt),
        .tc       (tm_tc)
    );

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        target_d  = target_q;
        up_d      = up_q;
        busy_d    = busy_q;
        stepped_d = 1'b0;
        zero_d    = 1'b0;
        // Zero-distance request completes one cycle after acceptance.
        done_d    = zero_q;
        tm_load   = 1'b0;
        tm_en     = 1'b0;
        tm_val    = STEP_LD;

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    target_d = req_code;
                    if (req_code == sel_q) begin
                        zero_d = 1'b1;
                    end else begin
                        state_d = MOVE;
                        busy_d  = 1'b1;
                        up_d    = (req_code > sel_q);
                        tm_load = 1'b1;
                    end
                end
            end
            MOVE: begin
                tm_en = 1'b1;
                if (tm_tc) begin
                    sel_d     = up_q ? sel_q + N_BITS'(1)
                                     : sel_q - N_BITS'(1);
                    stepped_d = 1'b1;
                    tm_load   = 1'b1;
                    if (sel_d == target_q) begin
                        state_d = SETTLE;
                        tm_val  = SETTLE_LD;
                    end
                end
            end
            SETTLE: begin
                tm_en = 1'b1;
                if (tm_tc) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Raise one cycle before a step; drop one cycle after it.
        // Raising wins so STEP_CYC=2 keeps blank high through MOVE.
        blank_d = blank_q;
        if (state_q == MOVE && tm_cnt == CW'(1)) begin
            blank_d = 1'b1;
        end else if (stepped_q) begin
            blank_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q   <= IDLE;
            sel_q     <= RST_SEL;
            target_q  <= RST_SEL;
            up_q      <= 1'b0;
            blank_q   <= 1'b0;
            stepped_q <= 1'b0;
            zero_q    <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            target_q  <= target_d;
            up_q      <= up_d;
            blank_q   <= blank_d;
            stepped_q <= stepped_d;
            zero_q    <= zero_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign sel       = sel_q;
    assign blank     = blank_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_mux_sel_stepper.sv
// Directed bench for mux_sel_stepper: default and fast-step instances.
// Expected values come from the documented step/settle timing.
module tb_mux_sel_stepper;

    logic       clk;
    logic       rstb;

    logic       req_valid_a;
    logic [3:0] req_code_a;
    logic       req_ready_a;
    logic [3:0] sel_a;
    logic       blank_a;
    logic       busy_a;
    logic       done_a;

    logic       req_valid_b;
    logic [1:0] req_code_b;
    logic       req_ready_b;
    logic [1:0] sel_b;
    logic       blank_b;
    logic       busy_b;
    logic       done_b;

    int n_chk;
    int n_err;

    mux_sel_stepper u_dut_a (
        .clk       (clk),
        .rstb      (rstb),
        .req_valid (req_valid_a),
        .req_code  (req_code_a),
        .req_ready (req_ready_a),
        .sel       (sel_a),
        .blank     (blank_a),
        .busy      (busy_a),
        .done      (done_a)
    );

    mux_sel_stepper #(
        .N_BITS     (2),
        .STEP_CYC   (2),
        .SETTLE_CYC (1),
        .RST_CODE   (0)
    ) u_dut_b (
        .clk       (clk),
        .rstb      (rstb),
        .req_valid (req_valid_b),
        .req_code  (req_code_b),
        .req_ready (req_ready_b),
        .sel       (sel_b),
        .blank     (blank_b),
        .busy      (busy_b),
        .done      (done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int which, input logic v, input int code);
        if (which == 0) begin
            req_valid_a = v;
            req_code_a  = 4'(code);
        end else begin
            req_valid_b = v;
            req_code_b  = 2'(code);
        end
    endtask

    function automatic int o_sel(input int which);
        return (which == 0) ? int'(sel_a) : int'(sel_b);
    endfunction

    function automatic int o_blank(input int which);
        return (which == 0) ? int'(blank_a) : int'(blank_b);
    endfunction

    function automatic int o_done(input int which);
        return (which == 0) ? int'(done_a) : int'(done_b);
    endfunction

    function automatic int o_busy(input int which);
        return (which == 0) ? int'(busy_a) : int'(busy_b);
    endfunction

    function automatic int o_ready(input int which);
        return (which == 0) ? int'(req_ready_a) : int'(req_ready_b);
    endfunction

    // Accept a request, then check every cycle up to the done pulse.
    // pulse_t: one-cycle stray request (code 9) driven after cycle t.
    // hold_t: from cycle t on, hold a request for code 9.
    task automatic walk(input int which, input int start, input int tgt,
                        input int s, input int set,
                        input int pulse_t, input int hold_t);
        int  d;
        int  tend;
        bit  up;
        up   = (tgt > start);
        d    = up ? tgt - start : start - tgt;
        tend = d * s + set;
        drive(which, 1'b1, tgt);
        tick();
        drive(which, 1'b0, tgt);
        for (int t = 0; t <= tend; t++) begin
            int n;
            int es;
            int eb;
            n = t / s;
            if (n > d) n = d;
            es = up ? start + n : start - n;
            eb = 0;
            for (int j = 1; j <= d; j++) begin
                if (t == j * s - 1 || t == j * s) eb = 1;
            end
            chk("sel",   o_sel(which),   es);
            chk("blank", o_blank(which), eb);
            chk("done",  o_done(which),  (t == tend) ? 1 : 0);
            chk("busy",  o_busy(which),  (t < tend) ? 1 : 0);
            chk("ready", o_ready(which), (t >= tend) ? 1 : 0);
            if (t == pulse_t) begin
                drive(which, 1'b1, 9);
            end else if (hold_t >= 0 && t >= hold_t) begin
                drive(which, 1'b1, 9);
            end else begin
                drive(which, 1'b0, tgt);
            end
            if (t < tend) tick();
        end
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rstb  = 1'b0;
        drive(0, 1'b0, 0);
        drive(1, 1'b0, 0);
        repeat (2) tick();

        chk("rst_sel",   int'(sel_a),       0);
        chk("rst_ready", int'(req_ready_a), 1);
        chk("rst_blank", int'(blank_a),     0);
        chk("rst_busy",  int'(busy_a),      0);
        chk("rst_done",  int'(done_a),      0);
        chk("rst_sel_b", int'(sel_b),       0);

        rstb = 1'b1;
        tick();

        walk(0, 0, 3, 4, 8, -1, -1);
        walk(0, 3, 0, 4, 8, -1, -1);
        walk(0, 0, 5, 4, 8, -1, -1);

        drive(0, 1'b1, 5);
        tick();
        drive(0, 1'b0, 5);
        chk("eq_done0",  int'(done_a),      0);
        chk("eq_busy0",  int'(busy_a),      0);
        chk("eq_ready0", int'(req_ready_a), 1);
        chk("eq_blank0", int'(blank_a),     0);
        tick();
        chk("eq_done1",  int'(done_a),      1);
        chk("eq_sel1",   int'(sel_a),       5);
        chk("eq_blank1", int'(blank_a),     0);
        chk("eq_busy1",  int'(busy_a),      0);
        tick();
        chk("eq_done2",  int'(done_a),      0);
        chk("eq_sel2",   int'(sel_a),       5);

        walk(0, 5, 2, 4, 8, 5, 17);
        walk(0, 2, 9, 4, 8, -1, -1);

        walk(1, 0, 3, 2, 1, -1, -1);
        tick();
        chk("b_done_end", int'(done_b), 0);

        rstb = 1'b0;
        tick();
        rstb = 1'b1;
        tick();
        chk("rst2_sel", int'(sel_a), 0);
        drive(0, 1'b1, 7);
        tick();
        drive(0, 1'b0, 7);
        repeat (8) tick();
        chk("mid_sel",   int'(sel_a),   2);
        chk("mid_blank", int'(blank_a), 1);
        chk("mid_busy",  int'(busy_a),  1);
        #2;
        rstb = 1'b0;
        #1;
        chk("async_sel",   int'(sel_a),       0);
        chk("async_busy",  int'(busy_a),      0);
        chk("async_blank", int'(blank_a),     0);
        chk("async_ready", int'(req_ready_a), 1);
        chk("async_done",  int'(done_a),      0);
        tick();
        rstb = 1'b1;
        for (int i = 0; i < 24; i++) begin
            tick();
            chk("post_done", int'(done_a), 0);
        end
        chk("post_sel",  int'(sel_a),  0);
        chk("post_busy", int'(busy_a), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
